// File: rtl/imem_loader_if.sv
// Handshake and IF memory write-port bundle between a host link, the loader and IF.
// master is the loader side; slave is the host/IF side.
interface imem_loader_if;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_last;
   logic        in_ready;
   logic [31:0] newPC;
   logic [31:0] W_Ins;
   logic        WE;

   modport master (
      input  in_valid, in_data, in_last,
      output in_ready, newPC, W_Ins, WE
   );

   modport slave (
      output in_valid, in_data, in_last,
      input  in_ready, newPC, W_Ins, WE
   );
endinterface

// File: rtl/imem_loader.sv
// Program loader: streams instruction words into IF memory while holding the core in reset,
// then presents the boot PC and releases the core.
module imem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 256,
   parameter int unsigned CNT_W     = 9
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   imem_loader_if.master    bus,
   output logic             core_rst,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] word_count
);

   typedef enum logic [2:0] {StIdle, StLoad, StFlush, StRelease, StDone, StError} state_t;

   localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_WORDS);

   state_t      state;
   logic [31:0] addr;
   logic        accept;

   assign bus.in_ready = (state == StLoad);
   assign accept       = bus.in_valid & bus.in_ready;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= StIdle;
         addr       <= BASE_ADDR;
         bus.newPC  <= BASE_ADDR;
         bus.W_Ins  <= '0;
         bus.WE     <= 1'b0;
         core_rst   <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         word_count <= '0;
      end else begin
         bus.WE <= 1'b0;
         case (state)
            StIdle, StDone, StError: begin
               if (start) begin
                  state      <= StLoad;
                  addr       <= BASE_ADDR;
                  word_count <= '0;
                  err        <= 1'b0;
                  core_rst   <= 1'b1;
                  done       <= 1'b0;
                  busy       <= 1'b1;
               end
            end
            StLoad: begin
               if (accept) begin
                  // A beat arriving with the counter already full is dropped, not written.
                  if (word_count == MaxCnt) begin
                     state <= StError;
                     err   <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     bus.WE     <= 1'b1;
                     bus.W_Ins  <= bus.in_data;
                     bus.newPC  <= addr;
                     addr       <= addr + 32'd4;
                     word_count <= word_count + 1'b1;
                     if (bus.in_last) begin
                        state <= StFlush;
                     end
                  end
               end
            end
            StFlush: begin
               state     <= StRelease;
               bus.newPC <= BASE_ADDR;
            end
            StRelease: begin
               state    <= StDone;
               core_rst <= 1'b0;
               done     <= 1'b1;
               busy     <= 1'b0;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: expected IF writes go into a scoreboard queue that a
// negedge monitor drains whenever WE is seen.
module tb_imem_loader;

   localparam logic [31:0] BASE = 32'hFFFF_FFF0;
   localparam int unsigned MAXW = 8;
   localparam int unsigned CW   = 4;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          core_rst, busy, done, err;
   logic [CW-1:0] word_count;

   imem_loader_if bus_if ();

   imem_loader #(
      .BASE_ADDR (BASE),
      .MAX_WORDS (MAXW),
      .CNT_W     (CW)
   ) dut (
      .CLK        (clk),
      .RST        (rst),
      .start      (start),
      .bus        (bus_if.master),
      .core_rst   (core_rst),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   int          n_total = 0;
   int          n_fail  = 0;
   wr_t         exp_q[$];
   logic [31:0] m_addr;
   int          m_wc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every WE must match the oldest outstanding expected write.
   always @(negedge clk) begin
      if (!rst && bus_if.WE === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_we", 32'd1, 32'd0);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", bus_if.newPC, e.a);
            chk("wr_data", bus_if.W_Ins, e.d);
         end
      end
   end

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      m_addr = BASE;
      m_wc   = 0;
      chk("start_in_ready", bus_if.in_ready, 1);
      chk("start_busy", busy, 1);
      chk("start_core_rst", core_rst, 1);
      chk("start_done", done, 0);
      chk("start_err", err, 0);
      chk("start_wc", word_count, 0);
   endtask

   task automatic load(input int n, input bit with_last, input bit gaps);
      for (int i = 0; i < n; i++) begin
         bit ovf;
         if (gaps) begin
            int g;
            g = $urandom_range(0, 2);
            for (int k = 0; k < g; k++) begin
               bus_if.in_valid = 1'b0;
               bus_if.in_data  = $urandom;
               start = ($urandom_range(0, 3) == 0);  // start while busy must be ignored
               @(negedge clk);
               chk("we_gap", bus_if.WE, 0);
               chk("ready_gap", bus_if.in_ready, 1);
            end
            start = 1'b0;
         end
         bus_if.in_valid = 1'b1;
         bus_if.in_data  = $urandom;
         bus_if.in_last  = with_last && (i == n - 1);
         ovf = (m_wc == MAXW);
         if (!ovf) begin
            exp_q.push_back('{a: m_addr, d: bus_if.in_data});
            m_addr = m_addr + 32'd4;
            m_wc++;
         end
         @(negedge clk);
         chk("we_beat", bus_if.WE, {31'd0, !ovf});
      end
      bus_if.in_valid = 1'b0;
      bus_if.in_last  = 1'b0;
   endtask

   task automatic finish_load();
      chk("flush_ready", bus_if.in_ready, 0);
      chk("flush_busy", busy, 1);
      chk("flush_core_rst", core_rst, 1);
      @(negedge clk);
      chk("rel_we", bus_if.WE, 0);
      chk("rel_pc", bus_if.newPC, BASE);
      chk("rel_core_rst", core_rst, 1);
      chk("rel_done", done, 0);
      @(negedge clk);
      chk("done_done", done, 1);
      chk("done_core_rst", core_rst, 0);
      chk("done_busy", busy, 0);
      chk("done_err", err, 0);
      chk("done_wc", word_count, m_wc);
      chk("done_pc", bus_if.newPC, BASE);
   endtask

   initial begin
      bus_if.in_valid = 1'b0;
      bus_if.in_data  = '0;
      bus_if.in_last  = 1'b0;

      #7;
      chk("rst_we", bus_if.WE, 0);
      chk("rst_pc", bus_if.newPC, BASE);
      chk("rst_ins", bus_if.W_Ins, 0);
      chk("rst_core_rst", core_rst, 1);
      chk("rst_ready", bus_if.in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_wc", word_count, 0);
      #5 rst = 1'b0;

      // in_valid in IDLE must not handshake
      bus_if.in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("idle_ready", bus_if.in_ready, 0);
         chk("idle_core_rst", core_rst, 1);
      end
      bus_if.in_valid = 1'b0;

      do_start();
      load(1, 1'b1, 1'b0);
      finish_load();

      do_start();
      load(4, 1'b1, 1'b0);
      finish_load();

      do_start();
      load(MAXW, 1'b1, 1'b1);
      finish_load();

      for (int r = 0; r < 10; r++) begin
         do_start();
         load($urandom_range(1, MAXW), 1'b1, 1'b1);
         finish_load();
      end

      // Overflow: one beat beyond capacity with no in_last
      do_start();
      load(MAXW + 1, 1'b0, 1'b1);
      chk("ovf_err", err, 1);
      chk("ovf_ready", bus_if.in_ready, 0);
      chk("ovf_core_rst", core_rst, 1);
      chk("ovf_done", done, 0);
      chk("ovf_busy", busy, 0);
      chk("ovf_wc", word_count, MAXW);
      bus_if.in_valid = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("err_sticky", err, 1);
         chk("err_ready", bus_if.in_ready, 0);
      end
      bus_if.in_valid = 1'b0;
      do_start();
      load(3, 1'b1, 1'b1);
      finish_load();

      // Reset mid-load, right after the second beat's write is visible
      do_start();
      load(2, 1'b0, 1'b0);
      #1 rst = 1'b1;
      #1;
      chk("abort_we", bus_if.WE, 0);
      chk("abort_wc", word_count, 0);
      chk("abort_ready", bus_if.in_ready, 0);
      chk("abort_pc", bus_if.newPC, BASE);
      chk("abort_core_rst", core_rst, 1);
      chk("abort_busy", busy, 0);
      bus_if.in_valid = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("post_abort_ready", bus_if.in_ready, 0);
         chk("post_abort_we", bus_if.WE, 0);
      end
      bus_if.in_valid = 1'b0;

      do_start();
      load(2, 1'b1, 1'b1);
      finish_load();

      @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_total - n_fail, n_total);
      $finish;
   end

endmodule
